// File: rtl/peak_hold_pkg.sv
// rtl/peak_hold_pkg.sv - shared state encoding and default sizes for peak_hold
package peak_hold_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP_MAX = 2'd1,
    S_CMP_MIN = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 4;
  localparam int WINDOW_DEF = 16;

endpackage

// File: rtl/comp.sv
// rtl/comp.sv - unsigned magnitude comparator shared by peak_hold
module comp #(
  parameter int W = 4
) (
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  output logic         great,
  output logic         equal,
  output logic         less
);

  assign great = (in_1 >  in_2);
  assign equal = (in_1 == in_2);
  assign less  = (in_1 <  in_2);

endmodule

// File: rtl/peak_hold.sv
// rtl/peak_hold.sv - windowed max/min tracker time-sharing one external comparator
// Optional comparator one-hot check enabled by macro PEAK_HOLD_SANITY_EN.
module peak_hold
  import peak_hold_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic              cmp_great,
  input  logic              cmp_equal,
  input  logic              cmp_less,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic              cmp_err
);

  localparam int CW = $clog2(WINDOW + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [DATA_W-1:0]  r_sample;
  logic [DATA_W-1:0]  r_max;
  logic [DATA_W-1:0]  r_min;
  logic [DATA_W-1:0]  r_out_max;
  logic [DATA_W-1:0]  r_out_min;
  logic               w_accept;
  logic               w_first;
  logic               w_last;
  logic               w_upd_max;
  logic               w_upd_min;

  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == CW'(WINDOW - 1));
  assign cmp_a     = r_sample;
  assign cmp_b     = (r_state == S_CMP_MIN) ? r_min : r_max;
  assign out_valid = (r_state == S_EMIT);
  assign out_max   = r_out_max;
  assign out_min   = r_out_min;

`ifdef PEAK_HOLD_SANITY_EN
  logic r_err;
  logic [1:0] w_flag_cnt;

  assign w_flag_cnt = {1'b0, cmp_great} + {1'b0, cmp_equal} + {1'b0, cmp_less};
  assign w_upd_max  = cmp_great;
  assign w_upd_min  = cmp_less;
  assign cmp_err    = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == S_CMP_MAX || r_state == S_CMP_MIN) && w_flag_cnt != 2'd1) begin
      r_err <= 1'b1;
    end
  end
`else
  // Equality is a no-update outcome, so it also masks a stray great/less.
  assign w_upd_max = cmp_great && !cmp_equal;
  assign w_upd_min = cmp_less && !cmp_equal;
  assign cmp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && !w_first) w_next = S_CMP_MAX;
      S_CMP_MAX: w_next = S_CMP_MIN;
      S_CMP_MIN: w_next = w_last ? S_EMIT : S_IDLE;
      S_EMIT:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sample  <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_out_max <= '0;
      r_out_min <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sample <= in_data;
            if (w_first) begin
              r_max <= in_data;
              r_min <= in_data;
              r_cnt <= CW'(1);
            end
          end
        end
        S_CMP_MAX: begin
          if (w_upd_max) r_max <= r_sample;
        end
        S_CMP_MIN: begin
          if (w_upd_min) r_min <= r_sample;
          r_cnt <= r_cnt + CW'(1);
          // Result registers capture the final extrema as the window closes.
          if (w_last) begin
            r_out_max <= r_max;
            r_out_min <= w_upd_min ? r_sample : r_min;
          end
        end
        S_EMIT: begin
          if (out_ready) r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
